fifo_reader: RTL and testbench
==============================

// Module: fifo_reader
// PURPOSE
//  Read-side master for the FIFO: pops a commanded burst of words and presents them on a valid/ready stream.
//  Sits between the FIFO read port and downstream consumers such as the systolic-array input skew and PE row feeder.
//  Hides the FIFO's one-cycle registered read latency behind a 2-entry skid buffer.
//  Sustains 1 word/cycle when the FIFO is non-empty and the sink is ready.
// PARAMETERS
//  WIDTH  8  data width; equals `p2_width
//  LEN_W  8  width of burst length; max burst = 2**LEN_W-1 words
// PORTS
//  clk            in   1      clock, all flops on posedge
//  rst_n          in   1      asynchronous active-low reset
//  cmd_start      in   1      1-cycle pulse: begin burst; sampled only in IDLE
//  cmd_len        in   LEN_W  words to drain; sampled with cmd_start
//  busy           out  1      high from cycle after accepted cmd_start until done
//  done           out  1      1-cycle pulse, cycle after last word handshaked
//  fifo_is_empty  in   1      FIFO empty flag
//  fifo_data_out  in   WIDTH  FIFO read data; valid the cycle after en_read
//  fifo_en_read   out  1      FIFO pop request
//  out_valid      out  1      stream valid
//  out_ready      in   1      stream ready; transfer when valid&ready at posedge
//  out_data       out  WIDTH  stream data; held stable while valid & !ready
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, fifo_en_read=0, out_valid=0, out_data=0.
//   - Reset clears remaining/inflight counters and the skid buffer.
//   - Reset mid-burst discards in-flight FIFO data; FIFO contents are not restored.
//  FSM IDLE -> RUN on cmd_start with cmd_len!=0; latches rem_issue=rem_out=cmd_len.
//   - cmd_len==0: IDLE -> DONE directly; no pops issued.
//   - RUN -> DONE when rem_out reaches 0 on the last handshake.
//   - DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
//   - cmd_start outside IDLE is ignored and not queued.
//  Pop issue (combinational):
//   - fifo_en_read = RUN & !fifo_is_empty & rem_issue!=0 & (occ + inflight + 1 <= 2 + pop_now).
//   - occ = skid entries (0..2); inflight = pop issued the previous cycle (0/1); pop_now = out_valid & out_ready.
//   - fifo_en_read is never high while fifo_is_empty=1, so the FIFO underflow path is never exercised.
//   - rem_issue decrements on each en_read.
//  Data capture: inflight=1 -> fifo_data_out is written into the skid tail that cycle.
//   - Simultaneous capture and output pop is legal; occupancy is unchanged.
//   - Capture into an empty buffer makes out_valid=1 the next cycle; total latency en_read -> out_valid is 2 cycles.
//  Output: out_data = skid head; out_valid = occ!=0.
//   - rem_out decrements on each handshake.
//   - Backpressure holds data; skid occupancy never exceeds 2 (overflow is an assertion).
//  Empty mid-burst: pops stall while empty and resume the cycle is_empty falls; busy stays 1.
//  Word order: output order equals FIFO pop order; no drops and no duplicates.
//  Counters: LEN_W bits; no wrap possible because decrement is gated by !=0.
// STRUCTURE
//  Shared package/include `sa_fifo_defs.vh`:
//   - `p2_width, `p2_depth.
//   - FSM encodings RD_IDLE=2'd0, RD_RUN=2'd1, RD_DONE=2'd2.
//  Sub-module skid_buf2: 2-entry register FIFO.
//   - Ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data, occ[1:0].
//   - fifo_reader instantiates one; FSM, counters and pop-issue logic stay in the top.
// TESTING (bench connects fifo_reader to FIFO, pushes via the push/pop_push/nop task style)
//  1. Push 94,87,-49; cmd_len=3, out_ready=1 -> out_data 94,87,-49 on consecutive cycles.
//     - First out_valid 2 cycles after first en_read; done 1 cycle after -49; busy back to 0.
//  2. FIFO empty, cmd_len=2, then push 5 at cycle 4 and 6 at cycle 9.
//     - en_read stays 0 while empty; output is 5 then 6.
//     - busy stays high through the gap; exactly 2 pops total.
//  3. FIFO full with 1..8, cmd_len=8, out_ready toggling 1,0,0,1...
//     - All 8 words come out in order, each held stable while stalled; occ never exceeds 2.
//     - FIFO is_empty=1 at the end.
//  4. cmd_len=0 -> done pulses next cycle; fifo_en_read never asserted; busy stays 0.
//  5. cmd_start pulsed again mid-burst with cmd_len=5, original len 3 -> ignored; exactly 3 words out.
//  6. rst_n=0 for 4 cycles mid-burst with 1 word in flight, FIFO holding 10,11.
//     - All outputs go to 0 immediately.
//     - After release, a new cmd_len=1 outputs the next FIFO word, not the discarded one.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side master.
// Data width, reader FSM encoding and the pop-issue credit check.
package fifo_reader_pkg;

   localparam int P2_WIDTH = 8;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_RUN  = 2'd1,
      RD_DONE = 2'd2
   } rd_state_e;

   // A pop may issue only if the skid buffer can absorb every word in flight.
   function automatic logic has_room(
      input logic [1:0] occ,
      input logic       inflight,
      input logic       pop_now
   );
      logic [2:0] need;
      logic [2:0] cap;
      need = {1'b0, occ} + {2'b00, inflight} + 3'd1;
      cap  = 3'd2 + {2'b00, pop_now};
      return need <= cap;
   endfunction

endpackage

// File: rtl/fifo_reader_skid_buf2.sv
// Two-entry register FIFO that absorbs the FIFO's registered read latency.
// Head entry is presented combinationally on rd_data.
module skid_buf2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [1:0]       occ
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (rd_en) rd_ptr <= ~rd_ptr;
         unique case ({wr_en, rd_en})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en && !rd_en && occ == 2'd2));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_en && occ == 2'd0));

endmodule

// File: rtl/fifo_reader.sv
// Read-side master: pops a commanded burst from the FIFO and streams it
// out on valid/ready, hiding the one-cycle read latency in a skid buffer.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int WIDTH = P2_WIDTH,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_start,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             busy,
   output logic             done,
   input  logic             fifo_is_empty,
   input  logic [WIDTH-1:0] fifo_data_out,
   output logic             fifo_en_read,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   rd_state_e        state;
   rd_state_e        state_nxt;
   logic [LEN_W-1:0] rem_issue;
   logic [LEN_W-1:0] rem_out;
   logic             inflight;
   logic             pop_now;
   logic [1:0]       occ;
   logic             accept;

   skid_buf2 #(.WIDTH(WIDTH)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (inflight),
      .wr_data (fifo_data_out),
      .rd_en   (pop_now),
      .rd_data (out_data),
      .occ     (occ)
   );

   assign out_valid = (occ != 2'd0);
   assign pop_now   = out_valid & out_ready;
   assign busy      = (state == RD_RUN);
   assign done      = (state == RD_DONE);
   assign accept    = (state == RD_IDLE) & cmd_start;

   assign fifo_en_read = busy & ~fifo_is_empty
                       & (rem_issue != '0)
                       & has_room(occ, inflight, pop_now);

   always_comb begin
      state_nxt = state;
      unique case (state)
         RD_IDLE: begin
            if (cmd_start)
               state_nxt = (cmd_len == '0) ? RD_DONE : RD_RUN;
         end
         RD_RUN: begin
            if (pop_now && rem_out == LEN_W'(1))
               state_nxt = RD_DONE;
         end
         RD_DONE: state_nxt = RD_IDLE;
         default: state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RD_IDLE;
         rem_issue <= '0;
         rem_out   <= '0;
         inflight  <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_en_read;
         if (accept) begin
            rem_issue <= cmd_len;
            rem_out   <= cmd_len;
         end else begin
            if (fifo_en_read)
               rem_issue <= rem_issue - LEN_W'(1);
            if (pop_now && rem_out != '0)
               rem_out <= rem_out - LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader driving a behavioural registered-read FIFO.
// Each scenario task checks its own results against hand-computed values.
module tb_fifo_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_start;
   logic [7:0] cmd_len;
   logic       busy;
   logic       done;
   logic       fifo_is_empty;
   logic [7:0] fifo_data_out;
   logic       fifo_en_read;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fifo_reader #(.WIDTH(8), .LEN_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_start     (cmd_start),
      .cmd_len       (cmd_len),
      .busy          (busy),
      .done          (done),
      .fifo_is_empty (fifo_is_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_en_read  (fifo_en_read),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data)
   );

   // Behavioural FIFO: one-cycle registered read, not reset by rst_n
   logic [7:0] fq[$];
   int         fcnt = 0;
   logic       push_en = 1'b0;
   logic [7:0] push_val = 8'd0;
   logic       fflush = 1'b0;

   assign fifo_is_empty = (fcnt == 0);

   always @(posedge clk) begin
      if (fflush) begin
         fq.delete();
      end else begin
         if (fifo_en_read && fq.size() != 0)
            fifo_data_out <= fq.pop_front();
         if (push_en) fq.push_back(push_val);
      end
      fcnt <= fq.size();
   end

   // Monitor sampled on the falling edge
   int         cyc = 0;
   logic       mon_clr = 1'b0;
   logic [7:0] got[$];
   int         pops, first_en, first_vld, last_hs, done_cyc, dones;
   int         stab_err, max_occ, en_empty;
   logic       busy_seen;
   logic       hold_v = 1'b0;
   logic [7:0] hold_d = 8'd0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_clr) begin
         got.delete();
         pops = 0; first_en = -1; first_vld = -1;
         last_hs = -1; done_cyc = -1; dones = 0;
         stab_err = 0; max_occ = 0; en_empty = 0;
         busy_seen = 1'b0;
      end else begin
         if (fifo_en_read) begin
            pops++;
            if (first_en < 0) first_en = cyc;
            if (fifo_is_empty) en_empty++;
         end
         if (out_valid && first_vld < 0) first_vld = cyc;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            last_hs = cyc;
         end
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
         if (busy) busy_seen = 1'b1;
         if (hold_v && (!out_valid || out_data !== hold_d)) stab_err++;
         if (int'(dut.u_skid.occ) > max_occ) max_occ = int'(dut.u_skid.occ);
      end
      hold_v = rst_n && out_valid && !out_ready;
      hold_d = out_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] v);
      push_en  = 1'b1;
      push_val = v;
      tick();
      push_en  = 1'b0;
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic flush();
      fflush = 1'b1;
      tick();
      fflush = 1'b0;
      tick();
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic start(input logic [7:0] len);
      cmd_start = 1'b1;
      cmd_len   = len;
      tick();
      cmd_start = 1'b0;
      cmd_len   = 8'd0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 100 && dones == 0; i++) tick();
      vectors++;
      if (dones == 0) begin
         errors++;
         $display("FAIL %s_timeout: done never seen, required within 100 cycles", tag);
      end
      nop(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_start = 1'b0; cmd_len = 8'd0; out_ready = 1'b1;
      nop(3);
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      vectors++; if (fifo_en_read !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", fifo_en_read); end
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      vectors++; if (out_data !== 8'd0) begin errors++; $display("FAIL rst_data: got %0d want 0", out_data); end
      rst_n = 1'b1;
      nop(2);
   endtask

   task automatic test_burst();
      logic [7:0] exp [3];
      exp[0] = 8'd94; exp[1] = 8'd87; exp[2] = 8'(-49);
      flush();
      for (int i = 0; i < 3; i++) push(exp[i]);
      tick();
      clr_mon();
      start(8'd3);
      wait_done("burst");
      vectors++;
      if (got.size() != 3) begin errors++; $display("FAIL burst_count: got %0d want 3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp[i]) begin errors++; $display("FAIL burst_word%0d: got %0d want %0d", i, got[i], exp[i]); end
      end
      vectors++;
      if (first_vld - first_en != 2) begin errors++; $display("FAIL burst_latency: got %0d want 2", first_vld - first_en); end
      vectors++;
      if (last_hs - first_vld != 2) begin errors++; $display("FAIL burst_backtoback: got span %0d want 2", last_hs - first_vld); end
      vectors++;
      if (done_cyc != last_hs + 1) begin errors++; $display("FAIL burst_done_timing: got %0d want %0d", done_cyc, last_hs + 1); end
      vectors++;
      if (dones != 1) begin errors++; $display("FAIL burst_done_pulses: got %0d want 1", dones); end
      vectors++;
      if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_empty_gap();
      flush();
      clr_mon();
      start(8'd2);
      nop(3);
      push(8'd5);
      nop(4);
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b want 1", busy); end
      push(8'd6);
      wait_done("gap");
      vectors++;
      if (en_empty != 0) begin errors++; $display("FAIL gap_en_while_empty: got %0d want 0", en_empty); end
      vectors++;
      if (pops != 2) begin errors++; $display("FAIL gap_pops: got %0d want 2", pops); end
      vectors++;
      if (got.size() != 2 || got[0] !== 8'd5 || got[1] !== 8'd6) begin
         errors++;
         $display("FAIL gap_words: got %p want 5,6", got);
      end
   endtask

   task automatic test_backpressure();
      flush();
      for (int i = 1; i <= 8; i++) push(8'(i));
      tick();
      clr_mon();
      start(8'd8);
      for (int i = 0; i < 200 && dones == 0; i++) begin
         out_ready = (i % 3 == 0);
         tick();
      end
      out_ready = 1'b1;
      wait_done("bp");
      vectors++;
      if (got.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         vectors++;
         if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL bp_word%0d: got %0d want %0d", i, got[i], i + 1); end
      end
      vectors++;
      if (stab_err != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", stab_err); end
      vectors++;
      if (max_occ > 2) begin errors++; $display("FAIL bp_occ: got %0d want <=2", max_occ); end
      vectors++;
      if (fifo_is_empty !== 1'b1) begin errors++; $display("FAIL bp_fifo_empty: got %b want 1", fifo_is_empty); end
   endtask

   task automatic test_zero_len();
      push(8'd77);
      tick();
      clr_mon();
      start(8'd0);
      vectors++;
      if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", done); end
      vectors++;
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy); end
      tick();
      vectors++;
      if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", done); end
      nop(2);
      vectors++;
      if (pops != 0 || busy_seen) begin
         errors++;
         $display("FAIL zero_activity: got pops=%0d busy_seen=%b want 0,0", pops, busy_seen);
      end
   endtask

   task automatic test_restart_ignored();
      flush();
      for (int i = 20; i < 25; i++) push(8'(i));
      tick();
      clr_mon();
      start(8'd3);
      tick();
      start(8'd5);
      wait_done("restart");
      nop(3);
      vectors++;
      if (pops != 3) begin errors++; $display("FAIL restart_pops: got %0d want 3", pops); end
      vectors++;
      if (got.size() != 3 || got[0] !== 8'd20 || got[2] !== 8'd22) begin
         errors++;
         $display("FAIL restart_words: got %p want 20,21,22", got);
      end
      vectors++;
      if (dones != 1) begin errors++; $display("FAIL restart_dones: got %0d want 1", dones); end
      vectors++;
      if (fcnt != 2) begin errors++; $display("FAIL restart_fifo_left: got %0d want 2", fcnt); end
   endtask

   task automatic test_reset_midburst();
      flush();
      push(8'd9); push(8'd10); push(8'd11);
      tick();
      clr_mon();
      start(8'd3);
      tick();
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({busy, done, fifo_en_read, out_valid} !== 4'b0000 || out_data !== 8'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got busy=%b done=%b en=%b valid=%b data=%0d want all 0",
                  busy, done, fifo_en_read, out_valid, out_data);
      end
      nop(4);
      vectors++;
      if (fcnt != 2) begin errors++; $display("FAIL midrst_fifo: got %0d want 2", fcnt); end
      rst_n = 1'b1;
      nop(2);
      clr_mon();
      start(8'd1);
      wait_done("midrst");
      vectors++;
      if (got.size() != 1 || got[0] !== 8'd10) begin
         errors++;
         $display("FAIL midrst_next_word: got %p want 10", got);
      end
      vectors++;
      if (pops != 1) begin errors++; $display("FAIL midrst_pops: got %0d want 1", pops); end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_empty_gap();
      test_backpressure();
      test_zero_len();
      test_restart_ignored();
      test_reset_midburst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
